// File: rtl/fp_pkg.sv
// Shared defaults and small types for the FP adder alignment / normalisation datapath.
package fp_pkg;

    localparam int DEF_MANT_W = 24;
    localparam int DEF_SH_W   = 8;

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_e;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } grs_t;

endpackage

// File: rtl/fp_shift_level.sv
// One barrel level: conditionally shifts the guard/round-extended mantissa by SHIFT,
// folding bits discarded on a right shift into the running sticky.
module fp_shift_level
    import fp_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int SHIFT  = 1
) (
    input  logic              sel_i,
    input  logic              dir_i,
    input  logic [MANT_W+1:0] data_i,
    input  logic              sticky_i,
    output logic [MANT_W+1:0] data_o,
    output logic              sticky_o
);

    always_comb begin
        data_o   = data_i;
        sticky_o = sticky_i;
        if (sel_i) begin
            if (shift_dir_e'(dir_i) == SHIFT_LEFT) begin
                data_o = data_i << SHIFT;
            end else begin
                data_o   = data_i >> SHIFT;
                sticky_o = sticky_i | (|data_i[SHIFT-1:0]);
            end
        end
    end

endmodule

// File: rtl/fp_align_shifter_pipe.sv
// Pipelined mantissa alignment/normalisation shifter with valid/ready on both sides;
// produces guard/round/sticky on right shifts, latency STAGES.
module fp_align_shifter_pipe
    import fp_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int SH_W   = DEF_SH_W,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [SH_W-1:0]   in_shamt,
    input  logic              in_dir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_guard,
    output logic              out_round,
    output logic              out_sticky
);

    localparam int DW    = MANT_W + 2;
    localparam int NLEV  = $clog2(DW);
    localparam int CMP_W = SH_W + 32;

    function automatic int lvl_lo(input int k);
        return (k * NLEV) / STAGES;
    endfunction

    function automatic int lvl_stage(input int i);
        int s;
        s = 0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (i >= lvl_lo(int'(k))) s = int'(k);
        end
        return s;
    endfunction

    logic [DW-1:0]     data_q   [STAGES];
    logic [DW-1:0]     data_d   [STAGES];
    logic              sticky_q [STAGES];
    logic              sticky_d [STAGES];
    logic [NLEV-1:0]   sh_q     [STAGES];
    logic [NLEV-1:0]   sh_d     [STAGES];
    logic              dir_q    [STAGES];
    logic              dir_d    [STAGES];
    logic [STAGES-1:0] valid_q, valid_d, en, src_valid;

    logic [DW-1:0]     src_data   [STAGES];
    logic              src_sticky [STAGES];
    logic [NLEV-1:0]   src_sh     [STAGES];
    logic              src_dir    [STAGES];
    logic [DW-1:0]     stg_data   [STAGES];
    logic              stg_sticky [STAGES];

    logic [DW-1:0]     lvl_in_d  [NLEV];
    logic [DW-1:0]     lvl_out_d [NLEV];
    logic              lvl_in_s  [NLEV];
    logic              lvl_out_s [NLEV];

    logic [CMP_W-1:0]  sh_cmp;
    logic [NLEV-1:0]   init_sh;
    logic [DW-1:0]     init_data;
    logic              init_sticky;
    logic              sat;
    grs_t              grs;

    // Out-of-range shifts are resolved up front: the barrel then sees zero data with
    // sticky preset, so every stage only has to carry the in-range shift bits.
    always_comb begin
        sh_cmp = {32'b0, in_shamt};
        if (shift_dir_e'(in_dir) == SHIFT_LEFT) sat = sh_cmp >= CMP_W'(MANT_W);
        else                                    sat = sh_cmp >= CMP_W'(DW);
        init_data   = sat ? '0 : {in_mant, 2'b00};
        init_sticky = sat && (shift_dir_e'(in_dir) == SHIFT_RIGHT) && (|in_mant);
    end

    for (genvar i = 0; i < NLEV; i++) begin : g_sh
        if (i < SH_W) begin : g_bit
            assign init_sh[i] = in_shamt[i];
        end else begin : g_zero
            assign init_sh[i] = 1'b0;
        end
    end

    always_comb begin
        src_data[0]   = init_data;
        src_sticky[0] = init_sticky;
        src_sh[0]     = init_sh;
        src_dir[0]    = in_dir;
        src_valid[0]  = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_data[k]   = data_q[k-1];
            src_sticky[k] = sticky_q[k-1];
            src_sh[k]     = sh_q[k-1];
            src_dir[k]    = dir_q[k-1];
            src_valid[k]  = valid_q[k-1];
        end
    end

    // Level i lives in stage lvl_stage(i); the first level of a stage reads that
    // stage's register input, later levels chain combinationally.
    for (genvar i = 0; i < NLEV; i++) begin : g_lvl
        localparam int K = lvl_stage(i);
        if (i == lvl_lo(K)) begin : g_first
            assign lvl_in_d[i] = src_data[K];
            assign lvl_in_s[i] = src_sticky[K];
        end else begin : g_chain
            assign lvl_in_d[i] = lvl_out_d[i-1];
            assign lvl_in_s[i] = lvl_out_s[i-1];
        end
        fp_shift_level #(.MANT_W(MANT_W), .SHIFT(1 << i)) u_level (
            .sel_i    (src_sh[K][i]),
            .dir_i    (src_dir[K]),
            .data_i   (lvl_in_d[i]),
            .sticky_i (lvl_in_s[i]),
            .data_o   (lvl_out_d[i]),
            .sticky_o (lvl_out_s[i])
        );
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (lvl_lo(k + 1) > lvl_lo(k)) begin : g_lv
            assign stg_data[k]   = lvl_out_d[lvl_lo(k + 1) - 1];
            assign stg_sticky[k] = lvl_out_s[lvl_lo(k + 1) - 1];
        end else begin : g_pass
            assign stg_data[k]   = src_data[k];
            assign stg_sticky[k] = src_sticky[k];
        end
    end

    // Stage k may advance unless it and every stage after it are full with out_ready low.
    always_comb begin
        logic full_after;
        full_after = 1'b1;
        for (int unsigned j = 0; j < STAGES; j++) begin
            full_after         = full_after & valid_q[STAGES-1-j];
            en[STAGES-1-j]     = out_ready || !full_after;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            data_d[k]   = data_q[k];
            sticky_d[k] = sticky_q[k];
            sh_d[k]     = sh_q[k];
            dir_d[k]    = dir_q[k];
            valid_d[k]  = valid_q[k];
            if (en[k]) begin
                data_d[k]   = stg_data[k];
                sticky_d[k] = stg_sticky[k];
                sh_d[k]     = src_sh[k];
                dir_d[k]    = src_dir[k];
                valid_d[k]  = src_valid[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k]   <= '0;
                sticky_q[k] <= 1'b0;
                sh_q[k]     <= '0;
                dir_q[k]    <= 1'b0;
            end
            valid_q <= '0;
        end else begin
            data_q   <= data_d;
            sticky_q <= sticky_d;
            sh_q     <= sh_d;
            dir_q    <= dir_d;
            valid_q  <= valid_d;
        end
    end

    assign grs        = '{guard: data_q[STAGES-1][1], round: data_q[STAGES-1][0],
                          sticky: sticky_q[STAGES-1]};
    assign in_ready   = en[0];
    assign out_valid  = valid_q[STAGES-1];
    assign out_mant   = data_q[STAGES-1][DW-1:2];
    assign out_guard  = grs.guard;
    assign out_round  = grs.round;
    assign out_sticky = grs.sticky;

endmodule
